sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO. It is the next-generation single-clock buffer for the fifo_intf-style bench.
- Adds a non-power-of-2 depth, threshold-programmable almost flags, a fill-level output, a read-valid strobe and sticky overflow/underflow error flags.
- Sits between any producer/consumer pair in one clock domain. Optional first-word-fall-through read mode.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2, need not be a power of 2)
AF_LEVEL, DEPTH-2, o_alm_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, o_alm_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous assert, active-high
i_wren  input  1  write request
i_wrdata  input  DATA_W  write data
i_rden  input  1  read request
o_rddata  output  DATA_W  read data
o_rdvalid  output  1  o_rddata valid
o_full  output  1  count == DEPTH
o_empty  output  1  count == 0
o_alm_full  output  1  count >= AF_LEVEL
o_alm_empty  output  1  count <= AE_LEVEL
o_count  output  $clog2(DEPTH+1)  current fill level
o_overflow  output  1  sticky: write attempted while full and not accepted
o_underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst high, async):
  - wr_ptr=0, rd_ptr=0, o_count=0.
  - o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0.
  - o_rddata=0, o_rdvalid=0, o_overflow=0, o_underflow=0.
  - Storage array is not reset.
- Read/write acceptance:
  - rd_acc = i_rden & !o_empty.
  - wr_acc = i_wren & (!o_full | rd_acc). A write while full is accepted only if a read is accepted in the same cycle.
- Pointers:
  - Each pointer increments on its accept and wraps DEPTH-1 -> 0 by explicit compare, not modulo-2^n.
- Count update:
  - count_next = count + wr_acc - rd_acc.
  - All flags are registered, computed from count_next, so they are valid in the cycle after the causing edge.
- Errors:
  - o_overflow sets on i_wren & !wr_acc.
  - o_underflow sets on i_rden & o_empty.
  - Both stay set until rst.
- Standard read mode (macro undefined):
  - Read latency 1. On rd_acc at edge N, o_rddata = mem[rd_ptr] and o_rdvalid=1 after edge N.
  - o_rdvalid=0 in cycles without rd_acc. o_rddata holds its last value.
- Simultaneous rd+wr when empty: write accepted, read rejected, o_underflow set, count becomes 1.
- Simultaneous rd+wr when full: both accepted, count unchanged, no overflow.
- Written data is first readable on the cycle after the write edge (o_empty deasserted).
- Reset mid-operation: all state returns to reset values immediately. Any in-flight o_rdvalid is dropped.

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined (first-word-fall-through mode):
  - o_rddata continuously presents the head word mem[rd_ptr]. o_rdvalid = !o_empty.
  - i_rden acts as a pop/acknowledge.
  - A word written into an empty FIFO at edge N is on o_rddata with o_rdvalid=1 after edge N.
- Undefined: standard 1-cycle registered read as above.
- Flags, count and errors are identical in both modes.

Decomposition:
- Package sync_fifo_pkg:
  - default DATA_W/DEPTH constants.
  - localparam-style helper function for pointer width ($clog2(DEPTH)) and count width ($clog2(DEPTH+1)).
  - elaboration checks on AF_LEVEL/AE_LEVEL ranges.
- One sub-module, sync_fifo_mem: simple dual-port array, with registered read in standard mode and combinational read in FWFT mode.
- Control, pointers, flags and errors stay in sync_fifo_param.

Test Plan:
All scenarios use DATA_W=8, DEPTH=6, AF_LEVEL=5, AE_LEVEL=1.
1. Reset, then write 0x11..0x16 back-to-back -> o_count 1..6; o_alm_empty drops when count=2; o_alm_full rises at 5; o_full at 6. A 7th write of 0x17 is ignored and o_overflow=1.
2. From full, assert i_rden for 7 cycles -> o_rddata 0x11..0x16 one cycle after each read with o_rdvalid=1. The 7th read gives o_rdvalid=0, o_underflow=1, o_empty=1.
3. Stream 20 words 0x00..0x13 with random rd/wr gaps, never exceeding 6 -> output in exact order across multiple pointer wraps 5->0; no error flags.
4. Fill to 6, then rd+wr (0xAA) in the same cycle -> o_count stays 6, o_overflow stays 0. 0xAA is read back after five older words.
5. Empty, rd+wr (0x5C) in the same cycle -> o_count=1, o_underflow=1, o_rdvalid=0. The next read returns 0x5C.
6. With count=4, pulse rst mid-cycle -> all outputs reach reset values before the next edge. With SYNC_FIFO_FWFT_EN, then write 0xA5 -> o_rddata=0xA5 with o_rdvalid=1 one cycle later, no i_rden needed.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared defaults and helpers for the sync_fifo_param single-clock FIFO.
//   DEF_DATA_W / DEF_DEPTH / DEF_AE_LEVEL : default parameter values
//   ptr_width(depth)    : bits needed to address DEPTH entries
//   cnt_width(depth)    : bits needed to hold a fill level of 0..DEPTH
//   cfg_ok(...)         : elaboration-time sanity check of the parameter set
// Optional feature macro: SYNC_FIFO_FWFT_EN (consumed by the other files).
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_AE_LEVEL = 2;

    // A depth of 1 would give $clog2 == 0; keep at least one address bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Legal ranges: DATA_W >= 1, DEPTH >= 2, AF_LEVEL in 1..DEPTH,
    // AE_LEVEL in 0..DEPTH-1.
    function automatic bit cfg_ok(input int data_w, input int depth,
                                  input int af_level, input int ae_level);
        return (data_w >= 1) && (depth >= 2) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Simple dual-port storage for sync_fifo_param. One write port, one read port.
// The array itself is never reset.
//   clk      : clock
//   rst      : async active-high reset (clears the registered read word only)
//   wr_en    : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr  : write address (0..DEPTH-1)
//   wr_data  : write data
//   rd_en    : read strobe (standard mode: loads rd_data from rd_addr)
//   rd_addr  : read address (0..DEPTH-1)
//   rd_data  : read data
// Macro SYNC_FIFO_FWFT_EN: when defined rd_data is a combinational view of
// mem[rd_addr]; otherwise rd_data is a register loaded on rd_en.
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is always visible; reset and rd_en are not needed here.
    assign rd_data = mem[rd_addr];

    logic unused_ok;
    assign unused_ok = rst ^ rd_en;
`else
    // Registered read. On a simultaneous read/write of the same entry
    // (full FIFO, rd+wr) the old word is returned, which is the head word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule : sync_fifo_mem

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with arbitrary (non power-of-2) depth,
// programmable almost-full/almost-empty thresholds, fill level, read-valid
// strobe and sticky overflow/underflow flags.
//   clk, rst      : clock, async active-high reset
//   i_wren        : write request,  i_wrdata : write data
//   i_rden        : read request (pop)
//   o_rddata      : read data,      o_rdvalid : o_rddata valid
//   o_full        : count == DEPTH, o_empty   : count == 0
//   o_alm_full    : count >= AF_LEVEL
//   o_alm_empty   : count <= AE_LEVEL
//   o_count       : current fill level
//   o_overflow    : sticky, write attempted while full and not accepted
//   o_underflow   : sticky, read attempted while empty
// Macro SYNC_FIFO_FWFT_EN: first-word-fall-through read mode when defined,
// 1-cycle registered read otherwise. Flags, count and errors are the same in
// both modes.
//
// Handshake: a write is taken on any rising edge where i_wren is high and
// the FIFO is not full, or is full but a read is taken in the same cycle.
// A read is taken on any rising edge where i_rden is high and the FIFO is
// not empty. Requests that are not taken are dropped (and flagged), never
// held over; there is no back-pressure beyond o_full/o_empty.
// -----------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wren,
    input  logic [DATA_W-1:0]            i_wrdata,
    input  logic                         i_rden,
    output logic [DATA_W-1:0]            o_rddata,
    output logic                         o_rdvalid,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_alm_full,
    output logic                         o_alm_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow,
    output logic                         o_underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

    if (!cfg_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_cfg
        $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q,  count_next;
    logic             full_q, empty_q, afull_q, aempty_q;
    logic             ovf_q, unf_q;
    logic             rd_acc, wr_acc;
    logic [DATA_W-1:0] mem_rdata;

    // Acceptance uses the registered flags; a write into a full FIFO only
    // succeeds when it is paired with an accepted read.
    assign rd_acc     = i_rden & ~empty_q;
    assign wr_acc     = i_wren & (~full_q | rd_acc);
    assign count_next = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);

    // Explicit wrap so non power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q  <= count_next;
            // Flags come from count_next so they line up with o_count.
            full_q   <= (count_next == CNT_FULL);
            empty_q  <= (count_next == '0);
            afull_q  <= (count_next >= CNT_AF);
            aempty_q <= (count_next <= CNT_AE);
            ovf_q    <= ovf_q | (i_wren & ~wr_acc);
            unf_q    <= unf_q | (i_rden & empty_q);
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (i_wrdata),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // The array is not reset, so the head word is masked while empty to keep
    // o_rddata at zero after reset.
    assign o_rddata  = empty_q ? '0 : mem_rdata;
    assign o_rdvalid = ~empty_q;
`else
    logic rdvalid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdvalid_q <= 1'b0;
        end else begin
            rdvalid_q <= rd_acc;
        end
    end

    assign o_rddata  = mem_rdata;
    assign o_rdvalid = rdvalid_q;
`endif

    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_alm_full  = afull_q;
    assign o_alm_empty = aempty_q;
    assign o_count     = count_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule : sync_fifo_param
